// File: rtl/updown_counter_checker.sv
// Passive checker for an up/down counter: runs a cycle-accurate model and logs mismatches.
// Optional CHK_RESYNC_EN: on a mismatch the model realigns to the observed count.
module updown_counter_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8,
  parameter int CHK_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_rst,
  input  logic             load,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] count,
  output logic             synced,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic [CHK_W-1:0] chk_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_obs
);

  typedef enum logic {S_SYNC, S_TRACK} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               pulse_q, pulse_d;
  logic               sticky_q, sticky_d;
  logic [ERR_W-1:0]   errc_q, errc_d;
  logic [CHK_W-1:0]   chkc_q, chkc_d;
  logic [WIDTH-1:0]   fexp_q, fexp_d;
  logic [WIDTH-1:0]   fobs_q, fobs_d;
  logic [WIDTH-1:0]   nxt_cnt, nxt_exp;
  logic               mismatch;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x, input logic cr,
                                           input logic ld, input logic en, input logic ud,
                                           input logic [WIDTH-1:0] d);
    if (cr)      return '0;
    else if (ld) return d;
    else if (en) return ud ? x + WIDTH'(1) : x - WIDTH'(1);
    else         return x;
  endfunction

  assign nxt_cnt  = nxt(count, cnt_rst, load, enable, up_down, d_in);
  assign nxt_exp  = nxt(exp_q, cnt_rst, load, enable, up_down, d_in);
  // Compare precedes the update, so a bad count in a load/cnt_rst cycle still counts.
  assign mismatch = (state_q == S_TRACK) && (count != exp_q);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    pulse_d  = mismatch;
    sticky_d = sticky_q;
    errc_d   = errc_q;
    chkc_d   = chkc_q;
    fexp_d   = fexp_q;
    fobs_d   = fobs_q;
    case (state_q)
      S_SYNC: begin
        exp_d = nxt_cnt;
        if (cnt_rst || load) state_d = S_TRACK;
      end
      S_TRACK: begin
        chkc_d = (&chkc_q) ? chkc_q : chkc_q + CHK_W'(1);
        exp_d  = nxt_exp;
        if (mismatch) begin
          errc_d   = (&errc_q) ? errc_q : errc_q + ERR_W'(1);
          sticky_d = 1'b1;
          if (!sticky_q) begin
            fexp_d = exp_q;
            fobs_d = count;
          end
`ifdef CHK_RESYNC_EN
          exp_d = nxt_cnt;
`else
          exp_d = nxt_exp;
`endif
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SYNC;
      exp_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      errc_q   <= '0;
      chkc_q   <= '0;
      fexp_q   <= '0;
      fobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      errc_q   <= errc_d;
      chkc_q   <= chkc_d;
      fexp_q   <= fexp_d;
      fobs_q   <= fobs_d;
    end
  end

  assign synced     = (state_q == S_TRACK);
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_count  = errc_q;
  assign chk_count  = chkc_q;
  assign first_exp  = fexp_q;
  assign first_obs  = fobs_q;

endmodule

// File: tb/tb_updown_counter_checker.sv
// Scoreboard bench for updown_counter_checker: a behavioural model queues expected
// outputs per cycle; a negedge monitor pops and compares them.
module tb_updown_counter_checker;

  logic       clk = 1'b0;
  logic       rst, cnt_rst, load, enable, up_down;
  logic [3:0] d_in, count;
  logic       synced, err_pulse, err_sticky;
  logic [7:0] err_count;
  logic [15:0] chk_count;
  logic [3:0] first_exp, first_obs;

  always #5 clk = ~clk;

  updown_counter_checker #(.WIDTH(4), .ERR_W(8), .CHK_W(16)) dut (
    .clk(clk), .rst(rst), .cnt_rst(cnt_rst), .load(load), .enable(enable),
    .up_down(up_down), .d_in(d_in), .count(count), .synced(synced),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .chk_count(chk_count), .first_exp(first_exp), .first_obs(first_obs)
  );

  typedef struct {
    int syn, pulse, sticky, errc, chkc, fexp, fobs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  int   ctr = 0;                 // true value of the observed counter
  int   m_syn = 0, m_exp = 0, m_pulse = 0, m_sticky = 0;
  int   m_errc = 0, m_chkc = 0, m_fexp = 0, m_fobs = 0;

  function automatic int nx(int x, bit cr, bit ld, bit en, bit ud, int d);
    if (cr) return 0;
    if (ld) return d;
    if (en) return ud ? (x + 1) % 16 : (x + 15) % 16;
    return x;
  endfunction

  task automatic chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("synced",     int'(synced),     e.syn);
      chk("err_pulse",  int'(err_pulse),  e.pulse);
      chk("err_sticky", int'(err_sticky), e.sticky);
      chk("err_count",  int'(err_count),  e.errc);
      chk("chk_count",  int'(chk_count),  e.chkc);
      chk("first_exp",  int'(first_exp),  e.fexp);
      chk("first_obs",  int'(first_obs),  e.fobs);
    end
  end

  // One clock cycle: drive controls and count (cnt<0 shows the true counter),
  // advance the model to the coming edge and queue what must be visible after it.
  task automatic cyc(bit r, bit cr, bit ld, bit en, bit ud, int d, int cnt);
    int shown;
    exp_t e;
    shown = (cnt < 0) ? ctr : cnt;
    rst = r; cnt_rst = cr; load = ld; enable = en; up_down = ud;
    d_in = 4'(d); count = 4'(shown);
    if (r) begin
      m_syn = 0; m_exp = 0; m_pulse = 0; m_sticky = 0;
      m_errc = 0; m_chkc = 0; m_fexp = 0; m_fobs = 0;
    end else if (m_syn == 0) begin
      m_pulse = 0;
      m_exp = nx(shown, cr, ld, en, ud, d);
      if (cr || ld) m_syn = 1;
    end else begin
      if (m_chkc < 65535) m_chkc++;
      if (shown != m_exp) begin
        m_pulse = 1;
        if (m_errc < 255) m_errc++;
        if (!m_sticky) begin m_fexp = m_exp; m_fobs = shown; end
        m_sticky = 1;
`ifdef CHK_RESYNC_EN
        m_exp = nx(shown, cr, ld, en, ud, d);
`else
        m_exp = nx(m_exp, cr, ld, en, ud, d);
`endif
      end else begin
        m_pulse = 0;
        m_exp = nx(m_exp, cr, ld, en, ud, d);
      end
    end
    e.syn = m_syn; e.pulse = m_pulse; e.sticky = m_sticky; e.errc = m_errc;
    e.chkc = m_chkc; e.fexp = m_fexp; e.fobs = m_fobs;
    q.push_back(e);
    ctr = nx(ctr, cr, ld, en, ud, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cnt_rst = 1'b0; load = 1'b0; enable = 1'b0; up_down = 1'b0;
    d_in = '0; count = '0;
    ctr = 5;
    // T1: reset, unsynced free-running, then counter reset aligns the model
    cyc(1, 0, 0, 0, 0, 0, -1);
    cyc(1, 0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, $urandom % 16, -1);
    cyc(0, 1, 0, 0, 0, 0, -1);
    cyc(0, 0, 0, 0, 0, 0, -1);
    // T2: load 7, count up 4, show B
    cyc(0, 0, 1, 0, 0, 7, -1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0, -1);
    // T3: counter jumps B->C; keep counting
    ctr = (ctr + 1) % 16;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0, -1);
    // T4: wrap both directions
    cyc(0, 0, 1, 0, 0, 15, -1);
    cyc(0, 0, 0, 1, 1, 0, -1);
    cyc(0, 0, 0, 1, 1, 0, -1);
    cyc(0, 0, 1, 0, 0, 0, -1);
    cyc(0, 0, 0, 1, 0, 0, -1);
    cyc(0, 0, 0, 0, 0, 0, -1);
    // T5: load beats enable; bad count during a load cycle; cnt_rst beats load
    cyc(0, 0, 1, 0, 0, 9, -1);
    cyc(0, 0, 1, 1, 1, 3, -1);
    cyc(0, 0, 0, 0, 0, 0, -1);
    cyc(0, 0, 1, 0, 0, 9, -1);
    cyc(0, 0, 1, 1, 1, 3, 10);
    cyc(0, 1, 1, 1, 1, 6, -1);
    cyc(0, 0, 0, 0, 0, 0, -1);
    // Random traffic with occasional counter jumps or corrupted reads
    for (int i = 0; i < 250; i++) begin
      int k;
      k = $urandom % 20;
      if (k == 0) ctr = (ctr + 1 + $urandom % 15) % 16;
      cyc(0, ($urandom % 16) == 0, ($urandom % 8) == 0, $urandom % 2, $urandom % 2,
          $urandom % 16, (k == 1) ? ((ctr + 3) % 16) : -1);
    end
    // T6: 300 consecutive mismatches, then reset clears everything
    cyc(0, 1, 0, 0, 0, 0, -1);
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0, 0, (i % 2) ? 1 : 2);
    cyc(1, 0, 0, 0, 0, 0, -1);
    cyc(0, 0, 0, 0, 0, 0, -1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_err_count", int'(err_count), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
